regfile_wb_arbiter: RTL and testbench

//  Single-write-port scheduler for the 32x32 register file.
//  - Shares the one write port (WE3/A3/WD3) among NREQ writeback requesters (ALU, LSU, debug) using round-robin valid/ready arbitration.
//  - Runs a zero-fill sequencer after reset and on demand.
//  - Sits between the writeback sources and the register file; the read path is untouched.

---
 rtl/regfile_wb_arbiter.sv | 163 ++++++++++++++++
 tb/tb_regfile_wb_arbiter.sv | 252 +++++++++++++++++++++++++
 2 files changed

// File: rtl/regfile_wb_arbiter.sv
// regfile_wb_arbiter
//   Single write-port scheduler for the 32x32 register file. It shares the
//   WE3/A3/WD3 port among NREQ writeback requesters using valid/ready
//   arbitration. After reset, and on demand, it runs a zero-fill sequence
//   over every register.
//
// Build option
//   WB_FIXED_PRIO_EN  defined   : fixed priority, lowest index wins
//                     undefined : round-robin (default)
//
// Ports
//   clk, rst      rising-edge clock; asynchronous active-high reset
//   req_valid     [NREQ]     requester i has a write pending
//   req_addr      [NREQ*AW]  requester i destination, slice [i*AW +: AW]
//   req_data      [NREQ*DW]  requester i data, slice [i*DW +: DW]
//   req_ready     [NREQ]     one-hot grant; a transfer is valid & ready
//   init_start    pulse in RUN that restarts the zero-fill
//   busy          high while the zero-fill runs
//   we_o/wa_o/wd_o  registered write port (WE3/A3/WD3)
module regfile_wb_arbiter #(
   parameter int NREQ = 3,
   parameter int AW   = 5,
   parameter int DW   = 32
) (
   input  logic               clk,
   input  logic               rst,
   input  logic [NREQ-1:0]    req_valid,
   input  logic [NREQ*AW-1:0] req_addr,
   input  logic [NREQ*DW-1:0] req_data,
   output logic [NREQ-1:0]    req_ready,
   input  logic               init_start,
   output logic               busy,
   output logic               we_o,
   output logic [AW-1:0]      wa_o,
   output logic [DW-1:0]      wd_o
);

   localparam int PW = (NREQ > 1) ? $clog2(NREQ) : 1;

   typedef enum logic {INIT, RUN} state_t;

   state_t          state, state_d;
   logic [AW-1:0]   cnt, cnt_d;
   logic            we_d;
   logic [AW-1:0]   wa_d;
   logic [DW-1:0]   wd_d;

   logic [NREQ-1:0] grant;
   logic [PW-1:0]   idx;
   logic            found;
   logic            xfer;
   logic [AW-1:0]   g_addr;
   logic [DW-1:0]   g_data;

`ifndef WB_FIXED_PRIO_EN
   logic [PW-1:0]   rr_ptr, rr_d, rr_next;
`endif

   // Find the first valid requester. In round-robin mode the scan starts at
   // rr_ptr and wraps. In fixed mode it starts at index 0.
   always_comb begin
      grant = '0;
      found = 1'b0;
      idx   = '0;
      for (int k = 0; k < NREQ; k++) begin
`ifdef WB_FIXED_PRIO_EN
         idx = PW'(k);
`else
         idx = PW'((int'(rr_ptr) + k) % NREQ);
`endif
         if (!found && req_valid[idx]) begin
            found      = 1'b1;
            grant[idx] = 1'b1;
         end
      end
   end

   // Mux the granted requester's payload. When the grant is requester k,
   // the round-robin pointer moves to the index just after k.
   always_comb begin
      g_addr  = '0;
      g_data  = '0;
`ifndef WB_FIXED_PRIO_EN
      rr_next = rr_ptr;
`endif
      for (int k = 0; k < NREQ; k++) begin
         if (grant[k]) begin
            g_addr  = req_addr[k*AW +: AW];
            g_data  = req_data[k*DW +: DW];
`ifndef WB_FIXED_PRIO_EN
            rr_next = PW'((k + 1) % NREQ);
`endif
         end
      end
   end

   // init_start suppresses the grant in its cycle, so a pending request
   // stays pending across the zero-fill and is not lost.
   assign req_ready = (state == RUN && !init_start) ? grant : '0;
   assign xfer      = |req_ready;
   assign busy      = (state == INIT);

   always_comb begin
      state_d = state;
      cnt_d   = cnt;
      we_d    = 1'b0;
      wa_d    = wa_o;
      wd_d    = wd_o;
`ifndef WB_FIXED_PRIO_EN
      rr_d    = rr_ptr;
`endif
      case (state)
         INIT: begin
            we_d  = 1'b1;
            wa_d  = cnt;
            wd_d  = '0;
            cnt_d = cnt + 1'b1;
            if (cnt == '1) begin
               state_d = RUN;
               cnt_d   = '0;
            end
         end
         RUN: begin
            if (init_start) begin
               state_d = INIT;
               cnt_d   = '0;
            end else if (xfer) begin
               // A write to x0 is consumed but not committed.
               we_d = (g_addr != '0);
               wa_d = g_addr;
               wd_d = g_data;
`ifndef WB_FIXED_PRIO_EN
               rr_d = rr_next;
`endif
            end
         end
         default: state_d = INIT;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state  <= INIT;
         cnt    <= '0;
         we_o   <= 1'b0;
         wa_o   <= '0;
         wd_o   <= '0;
`ifndef WB_FIXED_PRIO_EN
         rr_ptr <= '0;
`endif
      end else begin
         state  <= state_d;
         cnt    <= cnt_d;
         we_o   <= we_d;
         wa_o   <= wa_d;
         wd_o   <= wd_d;
`ifndef WB_FIXED_PRIO_EN
         rr_ptr <= rr_d;
`endif
      end
   end

endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// Testbench for regfile_wb_arbiter. Expected writes are queued when the
// stimulus is driven. A negedge monitor pops and compares every we_o=1
// cycle. Grant and status checks are done inline in each scenario task.
module tb_regfile_wb_arbiter;
   localparam int NREQ = 3;
   localparam int AW   = 5;
   localparam int DW   = 32;

   logic               clk = 1'b0;
   logic               rst;
   logic [NREQ-1:0]    req_valid;
   logic [NREQ*AW-1:0] req_addr;
   logic [NREQ*DW-1:0] req_data;
   logic [NREQ-1:0]    req_ready;
   logic               init_start;
   logic               busy;
   logic               we_o;
   logic [AW-1:0]      wa_o;
   logic [DW-1:0]      wd_o;

   typedef logic [AW+DW-1:0] exp_t;
   exp_t sb[$];
   exp_t mon_e;

   int n_chk  = 0;
   int n_fail = 0;
   int exp_rr = 0;

   regfile_wb_arbiter #(.NREQ(NREQ), .AW(AW), .DW(DW)) dut (
      .clk(clk), .rst(rst), .req_valid(req_valid), .req_addr(req_addr),
      .req_data(req_data), .req_ready(req_ready), .init_start(init_start),
      .busy(busy), .we_o(we_o), .wa_o(wa_o), .wd_o(wd_o)
   );

   always #5 clk = ~clk;

   // Scoreboard monitor: each committed write must match the queue head.
   always @(negedge clk) begin
      if (!rst && we_o) begin
         n_chk++;
         if (sb.size() == 0) begin
            n_fail++;
            $display("FAIL write_unexpected: got wa=%0d wd=%h, none expected", wa_o, wd_o);
         end else begin
            mon_e = sb.pop_front();
            if ({wa_o, wd_o} !== mon_e) begin
               n_fail++;
               $display("FAIL write_data: got wa=%0d wd=%h, expected wa=%0d wd=%h",
                        wa_o, wd_o, mon_e[AW+DW-1:DW], mon_e[DW-1:0]);
            end
         end
      end
   end

   function automatic logic [NREQ-1:0] exp_grant(input logic [NREQ-1:0] v, input int rr);
      logic [NREQ-1:0] g;
      int i;
      g = '0;
`ifdef WB_FIXED_PRIO_EN
      rr = 0;
`endif
      for (int k = 0; k < NREQ; k++) begin
         i = (rr + k) % NREQ;
         if (v[i] && g == '0) g[i] = 1'b1;
      end
      return g;
   endfunction

   function automatic int onehot_idx(input logic [NREQ-1:0] g);
      int r;
      r = 0;
      for (int k = 0; k < NREQ; k++) if (g[k]) r = k;
      return r;
   endfunction

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic set_req(input int i, input logic [AW-1:0] a, input logic [DW-1:0] d);
      req_addr[i*AW +: AW] = a;
      req_data[i*DW +: DW] = d;
   endtask

   task automatic push_init();
      for (int k = 0; k < 32; k++) sb.push_back({AW'(k), {DW{1'b0}}});
   endtask

   task automatic test_reset();
      rst = 1'b1; req_valid = '0; req_addr = '0; req_data = '0; init_start = 1'b0;
      tick(); tick();
      n_chk += 5;
      if (we_o !== 1'b0)      begin n_fail++; $display("FAIL reset_we: got %b, expected 0", we_o); end
      if (wa_o !== '0)        begin n_fail++; $display("FAIL reset_wa: got %0d, expected 0", wa_o); end
      if (wd_o !== '0)        begin n_fail++; $display("FAIL reset_wd: got %h, expected 0", wd_o); end
      if (busy !== 1'b1)      begin n_fail++; $display("FAIL reset_busy: got %b, expected 1", busy); end
      if (req_ready !== '0)   begin n_fail++; $display("FAIL reset_ready: got %b, expected 000", req_ready); end
   endtask

   // Release reset, then expect 32 zero-fill writes. busy falls with the wa=31 launch.
   task automatic test_init_seq();
      push_init();
      rst = 1'b0;
      for (int k = 1; k <= 32; k++) begin
         tick();
         n_chk += 2;
         if (req_ready !== '0) begin n_fail++; $display("FAIL init_ready c%0d: got %b, expected 000", k, req_ready); end
         if (busy !== (k < 32)) begin n_fail++; $display("FAIL init_busy c%0d: got %b, expected %b", k, busy, (k < 32)); end
      end
      exp_rr = 0;
   endtask

   task automatic test_single();
      logic [NREQ-1:0] g;
      set_req(0, 5'd5, 32'h6);
      req_valid = 3'b001;
      #1;
      g = exp_grant(req_valid, exp_rr);
      n_chk++;
      if (req_ready !== g) begin n_fail++; $display("FAIL single_ready: got %b, expected %b", req_ready, g); end
      sb.push_back({5'd5, 32'h6});
      exp_rr = (onehot_idx(g) + 1) % NREQ;
      tick();
      req_valid = '0;
      n_chk++;
      if (we_o !== 1'b1 || wa_o !== 5'd5) begin n_fail++; $display("FAIL single_latency: got we=%b wa=%0d, expected we=1 wa=5", we_o, wa_o); end
      tick();
   endtask

   task automatic test_back_to_back();
      logic [NREQ-1:0] g;
      int gi;
      for (int i = 0; i < NREQ; i++) set_req(i, AW'(i + 1), 32'hA0 + i);
      req_valid = '1;
      for (int c = 0; c < 6; c++) begin
         #1;
         g  = exp_grant(req_valid, exp_rr);
         gi = onehot_idx(g);
         n_chk++;
         if (req_ready !== g) begin n_fail++; $display("FAIL b2b_ready c%0d: got %b, expected %b", c, req_ready, g); end
         sb.push_back({AW'(gi + 1), 32'hA0 + gi});
         exp_rr = (gi + 1) % NREQ;
         tick();
      end
      req_valid = '0;
      tick();
   endtask

   task automatic test_x0_drop();
      logic [NREQ-1:0] g;
      int gi;
      set_req(1, 5'd0, 32'hFFFF_FFFF);
      req_valid = 3'b010;
      #1;
      n_chk++;
      if (req_ready !== 3'b010) begin n_fail++; $display("FAIL x0_ready: got %b, expected 010", req_ready); end
      exp_rr = 2;
      tick();
      req_valid = '0;
      n_chk++;
      if (we_o !== 1'b0) begin n_fail++; $display("FAIL x0_we: got %b, expected 0", we_o); end
      // The pointer must now sit at 2. With all three valid, requester 2 wins
      // under round-robin and requester 0 wins under fixed priority.
      for (int i = 0; i < NREQ; i++) set_req(i, AW'(i + 1), 32'hB0 + i);
      req_valid = '1;
      #1;
      g  = exp_grant(req_valid, exp_rr);
      gi = onehot_idx(g);
      n_chk++;
      if (req_ready !== g) begin n_fail++; $display("FAIL x0_rrptr: got %b, expected %b", req_ready, g); end
      sb.push_back({AW'(gi + 1), 32'hB0 + gi});
      exp_rr = (gi + 1) % NREQ;
      tick();
      req_valid = '0;
      tick();
   endtask

   task automatic test_init_start();
      logic [NREQ-1:0] g;
      int gi;
      for (int i = 0; i < NREQ; i++) set_req(i, AW'(i + 1), 32'hC0 + i);
      req_valid  = 3'b101;
      init_start = 1'b1;
      #1;
      n_chk++;
      if (req_ready !== '0) begin n_fail++; $display("FAIL istart_ready: got %b, expected 000", req_ready); end
      push_init();
      tick();
      // A second pulse in the middle of INIT must not restart the count.
      for (int k = 0; k < 32; k++) begin
         n_chk += 2;
         if (req_ready !== '0) begin n_fail++; $display("FAIL istart_init_ready c%0d: got %b, expected 000", k, req_ready); end
         if (busy !== 1'b1)    begin n_fail++; $display("FAIL istart_busy c%0d: got %b, expected 1", k, busy); end
         init_start = (k == 5);
         tick();
      end
      init_start = 1'b0;
      #1;
      g  = exp_grant(req_valid, exp_rr);
      gi = onehot_idx(g);
      n_chk += 2;
      if (busy !== 1'b0)   begin n_fail++; $display("FAIL istart_resume_busy: got %b, expected 0", busy); end
      if (req_ready !== g) begin n_fail++; $display("FAIL istart_resume_ready: got %b, expected %b", req_ready, g); end
      sb.push_back({AW'(gi + 1), 32'hC0 + gi});
      exp_rr = (gi + 1) % NREQ;
      tick();
      req_valid = '0;
      tick();
   endtask

   task automatic test_reset_mid_init();
      rst = 1'b1;
      tick();
      rst = 1'b0;
      push_init();
      repeat (10) tick();
      rst = 1'b1;
      #1;
      sb.delete();
      n_chk += 2;
      if (we_o !== 1'b0) begin n_fail++; $display("FAIL midrst_we: got %b, expected 0", we_o); end
      if (busy !== 1'b1) begin n_fail++; $display("FAIL midrst_busy: got %b, expected 1", busy); end
      tick(); tick();
      n_chk++;
      if (we_o !== 1'b0 || wa_o !== '0) begin n_fail++; $display("FAIL midrst_hold: got we=%b wa=%0d, expected 0/0", we_o, wa_o); end
      push_init();
      rst = 1'b0;
      repeat (32) tick();
      exp_rr = 0;
      n_chk++;
      if (busy !== 1'b0) begin n_fail++; $display("FAIL midrst_done_busy: got %b, expected 0", busy); end
      tick();
      n_chk++;
      if (sb.size() != 0) begin n_fail++; $display("FAIL midrst_drain: got %0d writes outstanding, expected 0", sb.size()); end
   endtask

   initial begin
      test_reset();
      test_init_seq();
      test_single();
      test_back_to_back();
      test_x0_drop();
      test_init_start();
      test_reset_mid_init();
      n_chk++;
      if (sb.size() != 0) begin n_fail++; $display("FAIL final_drain: got %0d writes outstanding, expected 0", sb.size()); end
      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
